// File: rtl/joy_db15_reader_if.sv
// Pin and output bundle between the DB15 reader, the user-port adapter and the joystick mux.
// master = reader side, slave = adapter/consumer side.
interface joy_db15_reader_if;
   logic        JOY_DATA;
   logic        JOY_CLK;
   logic        JOY_LOAD;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic        frame_done;

   modport master (
      input  JOY_DATA,
      output JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_done
   );

   modport slave (
      output JOY_DATA,
      input  JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_done
   );
endinterface

// File: rtl/joy_db15_reader.sv
// DB15 adapter reader: loads/shifts a 24-bit serial frame forever and publishes two 12-bit player words.
// Optional two-frame agreement filter selected by macro JOY_DB15_FILTER_EN.
module joy_db15_reader #(
   parameter int CLK_DIV   = 48,
   parameter int GAP_TICKS = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   joy_db15_reader_if.master joy
);
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);
   localparam logic [4:0] BIT_LAST = 5'd23;

   typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_GAP} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  gap_q, gap_d;
   logic [4:0]  bit_q, bit_d;
   logic        phase_b_q, phase_b_d;
   logic [23:0] shreg_q, shreg_d;
   logic        sync1_q, sync2_q;
   logic        load_q, load_d;
   logic        jclk_q, jclk_d;
   logic        done_q, done_d;
   logic [11:0] joy1_q, joy1_d;
   logic [11:0] joy2_q, joy2_d;
   logic        tick;
   logic        frame_end;
`ifdef JOY_DB15_FILTER_EN
   logic [23:0] prev_q, prev_d;
   logic        prev_vld_q, prev_vld_d;
`endif

   assign tick      = (cnt_q == DIV_LAST);
   assign frame_end = tick && (state_q == ST_SHIFT) && phase_b_q && (bit_q == BIT_LAST);

   always_comb begin
      cnt_d     = tick ? 8'd0 : cnt_q + 8'd1;
      state_d   = state_q;
      gap_d     = gap_q;
      bit_d     = bit_q;
      phase_b_d = phase_b_q;
      shreg_d   = shreg_q;
      jclk_d    = jclk_q;
      // One-cycle lag on the load strobe keeps its low time a full tick, also straight after reset.
      load_d    = (state_q != ST_LOAD);
      done_d    = frame_end;
      joy1_d    = joy1_q;
      joy2_d    = joy2_q;
`ifdef JOY_DB15_FILTER_EN
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
`endif
      if (tick) begin
         case (state_q)
            ST_LOAD: begin
               bit_d     = 5'd0;
               phase_b_d = 1'b0;
               state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (!phase_b_q) begin
                  shreg_d[bit_q] = ~sync2_q;
                  jclk_d         = 1'b1;
                  phase_b_d      = 1'b1;
               end else begin
                  jclk_d    = 1'b0;
                  phase_b_d = 1'b0;
                  bit_d     = bit_q + 5'd1;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_GAP;
                     gap_d   = 8'd0;
                  end
               end
            end
            ST_GAP: begin
               if (gap_q == GAP_LAST) state_d = ST_LOAD;
               else                   gap_d   = gap_q + 8'd1;
            end
            default: state_d = ST_LOAD;
         endcase
      end
      if (frame_end) begin
`ifdef JOY_DB15_FILTER_EN
         if (prev_vld_q && (prev_q == shreg_q)) begin
            joy1_d = shreg_q[11:0];
            joy2_d = shreg_q[23:12];
         end
         prev_d     = shreg_q;
         prev_vld_d = 1'b1;
`else
         joy1_d = shreg_q[11:0];
         joy2_d = shreg_q[23:12];
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_LOAD;
         cnt_q     <= 8'd0;
         gap_q     <= 8'd0;
         bit_q     <= 5'd0;
         phase_b_q <= 1'b0;
         shreg_q   <= 24'd0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         load_q    <= 1'b1;
         jclk_q    <= 1'b0;
         done_q    <= 1'b0;
         joy1_q    <= 12'd0;
         joy2_q    <= 12'd0;
`ifdef JOY_DB15_FILTER_EN
         prev_q     <= 24'd0;
         prev_vld_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         bit_q     <= bit_d;
         phase_b_q <= phase_b_d;
         shreg_q   <= shreg_d;
         sync1_q   <= joy.JOY_DATA;
         sync2_q   <= sync1_q;
         load_q    <= load_d;
         jclk_q    <= jclk_d;
         done_q    <= done_d;
         joy1_q    <= joy1_d;
         joy2_q    <= joy2_d;
`ifdef JOY_DB15_FILTER_EN
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
`endif
      end
   end

   assign joy.JOY_CLK    = jclk_q;
   assign joy.JOY_LOAD   = load_q;
   assign joy.frame_done = done_q;
   assign joy.joystick1  = {4'b0000, joy1_q};
   assign joy.joystick2  = {4'b0000, joy2_q};
endmodule

// File: tb/tb_joy_db15_reader.sv
// Bench for joy_db15_reader: default-rate instance for pin timing/reset, fast instance for data vectors.
module tb_joy_db15_reader;
`ifdef JOY_DB15_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   joy_db15_reader_if if_s ();
   joy_db15_reader_if if_f ();

   joy_db15_reader u_slow (
      .clk     (clk),
      .reset_n (reset_n),
      .joy     (if_s)
   );

   joy_db15_reader #(.CLK_DIV(4), .GAP_TICKS(1)) u_fast (
      .clk     (clk),
      .reset_n (reset_n),
      .joy     (if_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Adapter models: wire-level pattern, bit 0 presented after load, advance on each shift-clock rise.
   logic [23:0] pat_s, pat_f;
   int idx_s = 0;
   int idx_f = 0;
   always @(posedge if_s.JOY_CLK or negedge if_s.JOY_LOAD)
      if (!if_s.JOY_LOAD) idx_s <= 0; else idx_s <= idx_s + 1;
   always @(posedge if_f.JOY_CLK or negedge if_f.JOY_LOAD)
      if (!if_f.JOY_LOAD) idx_f <= 0; else idx_f <= idx_f + 1;
   assign if_s.JOY_DATA = (idx_s < 24) ? pat_s[idx_s[4:0]] : 1'b1;
   assign if_f.JOY_DATA = (idx_f < 24) ? pat_f[idx_f[4:0]] : 1'b1;

   logic [1:0] fd;
   assign fd = {if_f.frame_done, if_s.frame_done};

   typedef struct {
      string       name;
      logic [23:0] pat;
      logic [15:0] e1;
      logic [15:0] e2;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_fd(input int idx, input string tag, output int at);
      int n;
      n  = 0;
      at = -1;
      do begin
         @(negedge clk);
         n++;
      end while (!fd[idx] && n < 4000);
      if (fd[idx]) at = cyc;
      else begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no frame_done within %0d cycles, expected a pulse", tag, n);
      end
   endtask

   // Called right after reset_n rises on a negedge; follows the slow instance through its first frame.
   task automatic post_reset_frame(input string tag, input logic [15:0] e1,
                                   input logic [15:0] e2, output int at);
      int n, low, pulses, wmin, wmax, w, done_n;
      logic pclk;
      n = 0; low = 0; pulses = 0; wmin = 9999; wmax = 0; w = 0; done_n = -1; pclk = 1'b0;
      at = -1;
      while (n < 4000 && done_n < 0) begin
         @(negedge clk);
         n++;
         if (!if_s.JOY_LOAD) low++;
         if (if_s.JOY_CLK) w++;
         else if (pclk) begin
            pulses++;
            if (w < wmin) wmin = w;
            if (w > wmax) wmax = w;
            w = 0;
         end
         pclk = if_s.JOY_CLK;
         if (if_s.frame_done) begin
            done_n = n;
            at     = cyc;
         end
      end
      chk({tag, "_load_low"}, low, 48);
      chk({tag, "_clk_pulses"}, pulses, 24);
      chk({tag, "_clk_high_min"}, wmin, 48);
      chk({tag, "_clk_high_max"}, wmax, 48);
      chk({tag, "_first_done_at"}, done_n, 2352);
      chk({tag, "_j1"}, if_s.joystick1, e1);
      chk({tag, "_j2"}, if_s.joystick2, e2);
   endtask

   initial begin
      int t0, t1, rises, n;
      logic p;

      vecs[0] = '{"b0_b12",  24'hFFEFFE, 16'h0001, 16'h0001};
      vecs[1] = '{"open",    24'hFFFFFF, 16'h0000, 16'h0000};
      vecs[2] = '{"a5a_5a5", 24'hA5A5A5, 16'h0A5A, 16'h05A5};
      vecs[3] = '{"all",     24'h000000, 16'h0FFF, 16'h0FFF};
      vecs[4] = '{"b11_b23", 24'h7FF7FF, 16'h0800, 16'h0800};
      vecs[5] = '{"b5",      24'hFFFFDF, 16'h0020, 16'h0000};
      vecs[6] = '{"p2_only", 24'h000FFF, 16'h0000, 16'h0FFF};

      reset_n = 1'b0;
      pat_s   = 24'hFFEFFE;
      pat_f   = 24'hFFFFFF;
      repeat (3) @(negedge clk);
      chk("rst_load",  if_s.JOY_LOAD, 1'b1);
      chk("rst_clk",   if_s.JOY_CLK, 1'b0);
      chk("rst_j1",    if_s.joystick1, 16'h0000);
      chk("rst_j2",    if_s.joystick2, 16'h0000);
      chk("rst_done",  if_s.frame_done, 1'b0);
      chk("rst_fast_load", if_f.JOY_LOAD, 1'b1);
      reset_n = 1'b1;

      post_reset_frame("first", FILT ? 16'h0000 : 16'h0001, FILT ? 16'h0000 : 16'h0001, t0);
      wait_fd(0, "slow_second", t1);
      chk("slow_period", t1 - t0, 3120);
      chk("slow_second_j1", if_s.joystick1, 16'h0001);
      chk("slow_second_j2", if_s.joystick2, 16'h0001);
      chk("fast_open_j1", if_f.joystick1, 16'h0000);
      chk("fast_open_j2", if_f.joystick2, 16'h0000);

      wait_fd(1, "fast_a", t0);
      wait_fd(1, "fast_b", t1);
      chk("fast_period", t1 - t0, 200);

      for (int i = 0; i < 7; i++) begin
         pat_f = vecs[i].pat;
         repeat (3) wait_fd(1, vecs[i].name, t0);
         chk({vecs[i].name, "_j1"}, if_f.joystick1, vecs[i].e1);
         chk({vecs[i].name, "_j2"}, if_f.joystick2, vecs[i].e2);
      end

      // Single-frame glitch versus a press held for two frames.
      pat_f = 24'hFFFFFF;
      repeat (3) wait_fd(1, "quiet", t0);
      chk("quiet_j1", if_f.joystick1, 16'h0000);
      pat_f = 24'hFFFFDF;
      wait_fd(1, "single_n", t0);
      chk("single_n_j1", if_f.joystick1, FILT ? 16'h0000 : 16'h0020);
      pat_f = 24'hFFFFFF;
      wait_fd(1, "single_n1", t0);
      chk("single_n1_j1", if_f.joystick1, 16'h0000);
      pat_f = 24'hFFFFDF;
      wait_fd(1, "pair_n", t0);
      chk("pair_n_j1", if_f.joystick1, FILT ? 16'h0000 : 16'h0020);
      wait_fd(1, "pair_n1", t0);
      chk("pair_n1_j1", if_f.joystick1, 16'h0020);

      // Abort a slow frame in the middle of bit 10.
      pat_s = 24'hFFFFFE;
      wait_fd(0, "pre_abort", t0);
      rises = 0; n = 0; p = 1'b0;
      while (rises < 11 && n < 5000) begin
         @(negedge clk);
         n++;
         if (if_s.JOY_CLK && !p) rises++;
         p = if_s.JOY_CLK;
      end
      chk("reach_bit10", rises, 11);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_rst_load", if_s.JOY_LOAD, 1'b1);
      chk("abort_rst_clk",  if_s.JOY_CLK, 1'b0);
      chk("abort_rst_j1",   if_s.joystick1, 16'h0000);
      reset_n = 1'b1;
      post_reset_frame("after_abort", FILT ? 16'h0000 : 16'h0001, 16'h0000, t0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
